// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul operand sequencer (state encoding, lane sizing).
package matmul_pkg;

  localparam int unsigned MAT_LANES = 4;
  localparam int unsigned DEF_DW    = 8;

  typedef logic [MAT_LANES*DEF_DW-1:0] lane_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/matmul_operand_sequencer_skew.sv
// operand_skew_line: lane i delays the RAM word element by 1+i cycles, zeroing data outside its valid window.
module operand_skew_line
  import matmul_pkg::*;
#(
  parameter int unsigned MAT_DIM = MAT_LANES,
  parameter int unsigned DW      = DEF_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_vld,
  input  logic [MAT_DIM*DW-1:0] in_word,
  output logic [MAT_DIM*DW-1:0] out_data,
  output logic [MAT_DIM-1:0]    out_vld
);

  for (genvar gi = 0; gi < MAT_DIM; gi++) begin : g_lane
    logic [DW-1:0] dly_r [0:gi];
    logic [gi:0]   vld_r;

    // Per-lane delay chain; data is forced to zero when the captured word is not valid.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= gi; j++) begin
          dly_r[j] <= '0;
        end
        vld_r <= '0;
      end else begin
        dly_r[0] <= in_vld ? in_word[gi*DW +: DW] : {DW{1'b0}};
        vld_r[0] <= in_vld;
        for (int j = 1; j <= gi; j++) begin
          dly_r[j] <= dly_r[j-1];
          vld_r[j] <= vld_r[j-1];
        end
      end
    end

    assign out_data[gi*DW +: DW] = dly_r[gi];
    assign out_vld[gi]           = vld_r[gi];
  end

endmodule

// File: rtl/matmul_operand_sequencer.sv
// Operand fetch/skew engine for the systolic matmul array: run FSM, RAM address counters, two skew lines.
// Optional MATMUL_SEQ_PERF_EN adds perf_cycles (busy cycles of the last run, saturating).
module matmul_operand_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned MAT_DIM   = MAT_LANES,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned AW        = 7,
  parameter int unsigned KW        = 8,
  parameter int unsigned DRAIN_CYC = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_mat_mul,
  output logic                  done_mat_mul,
  output logic                  busy,
  input  logic [KW-1:0]         cfg_k,
  input  logic [AW-1:0]         addr_base_a,
  input  logic [AW-1:0]         addr_base_b,
  output logic                  en_a,
  output logic                  en_b,
  output logic [AW-1:0]         addr_a,
  output logic [AW-1:0]         addr_b,
  input  logic [MAT_DIM*DW-1:0] rdata_a,
  input  logic [MAT_DIM*DW-1:0] rdata_b,
  output logic [MAT_DIM*DW-1:0] a_data,
  output logic [MAT_DIM*DW-1:0] b_data,
  output logic [MAT_DIM-1:0]    a_vld,
  output logic [MAT_DIM-1:0]    b_vld
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [15:0]           perf_cycles
`endif
);

  localparam int unsigned CW = KW + 1;

  seq_state_t    state_r, state_n;
  logic [CW-1:0] cnt_r;
  logic [KW-1:0] k_r;
  logic [CW-1:0] k_ext_s;
  logic          fetch_last_s, drain_last_s;
  logic          en_r, rd_vld_r, busy_r, done_r;
  logic [AW-1:0] addr_a_r, addr_b_r;

  assign k_ext_s      = {1'b0, k_r};
  assign fetch_last_s = (cnt_r == (k_ext_s - CW'(1)));
  assign drain_last_s = (cnt_r == (k_ext_s + CW'(MAT_DIM + DRAIN_CYC - 1)));

  // Next-state logic; DONE is held until the registered done has been visible for a cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start_mat_mul) begin
          state_n = (cfg_k == '0) ? DONE : FETCH;
        end else begin
          state_n = IDLE;
        end
      end
      FETCH: begin
        if (fetch_last_s) state_n = DRAIN;
        else              state_n = FETCH;
      end
      DRAIN: begin
        if (drain_last_s) state_n = DONE;
        else              state_n = DRAIN;
      end
      DONE: begin
        if (!start_mat_mul && done_r) state_n = IDLE;
        else                          state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, run counter, sampled config and all registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      k_r      <= '0;
      en_r     <= 1'b0;
      rd_vld_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      addr_a_r <= '0;
      addr_b_r <= '0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= (state_r == IDLE) ? '0 : cnt_r + CW'(1);
      if (state_r == IDLE && start_mat_mul) k_r <= cfg_k;
      en_r     <= (state_n == FETCH);
      rd_vld_r <= en_r;
      busy_r   <= (state_n == FETCH) || (state_n == DRAIN);
      done_r   <= (state_r == DONE) && (state_n == DONE);
      if (state_n == FETCH) begin
        addr_a_r <= (state_r == IDLE) ? addr_base_a : addr_a_r + AW'(1);
        addr_b_r <= (state_r == IDLE) ? addr_base_b : addr_b_r + AW'(1);
      end else begin
        addr_a_r <= '0;
        addr_b_r <= '0;
      end
    end
  end

  assign en_a         = en_r;
  assign en_b         = en_r;
  assign addr_a       = addr_a_r;
  assign addr_b       = addr_b_r;
  assign busy         = busy_r;
  assign done_mat_mul = done_r;

  operand_skew_line #(.MAT_DIM(MAT_DIM), .DW(DW)) u_skew_a (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (rd_vld_r),
    .in_word  (rdata_a),
    .out_data (a_data),
    .out_vld  (a_vld)
  );

  operand_skew_line #(.MAT_DIM(MAT_DIM), .DW(DW)) u_skew_b (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (rd_vld_r),
    .in_word  (rdata_b),
    .out_data (b_data),
    .out_vld  (b_vld)
  );

`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] perf_r;

  // Busy-cycle counter: cleared when a run leaves IDLE, held afterwards, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_r <= 16'd0;
    end else if (state_r == IDLE && state_n != IDLE) begin
      perf_r <= 16'd0;
    end else if (busy_r && perf_r != 16'hFFFF) begin
      perf_r <= perf_r + 16'd1;
    end
  end

  assign perf_cycles = perf_r;
`endif

endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Directed bench for matmul_operand_sequencer: RAM model, cycle-indexed behavioural model, systolic result check.
module tb_matmul_operand_sequencer;
  localparam int MAT_DIM = 4, DW = 8, AW = 7, KW = 8, DRAIN_CYC = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic start_mat_mul = 1'b0, done_mat_mul, busy;
  logic [KW-1:0] cfg_k = '0;
  logic [AW-1:0] addr_base_a = '0, addr_base_b = '0;
  logic en_a, en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [31:0] rdata_a = '0, rdata_b = '0;
  logic [31:0] a_data, b_data;
  logic [3:0]  a_vld, b_vld;
`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  matmul_operand_sequencer #(.MAT_DIM(MAT_DIM), .DW(DW), .AW(AW), .KW(KW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .reset(reset), .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul), .busy(busy),
    .cfg_k(cfg_k), .addr_base_a(addr_base_a), .addr_base_b(addr_base_b),
    .en_a(en_a), .en_b(en_b), .addr_a(addr_a), .addr_b(addr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .a_data(a_data), .b_data(b_data), .a_vld(a_vld), .b_vld(b_vld)
`ifdef MATMUL_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  logic [31:0] mem_a [0:127];
  logic [31:0] mem_b [0:127];
  always @(posedge clk) begin
    if (en_a) rdata_a <= mem_a[addr_a];
    if (en_b) rdata_b <= mem_b[addr_b];
  end

  int a_mat [0:3][0:3] = '{'{8,4,6,8}, '{3,3,3,7}, '{5,2,1,6}, '{9,1,0,5}};
  int b_mat [0:3][0:3] = '{'{1,1,3,0}, '{0,1,4,3}, '{3,5,3,1}, '{9,6,3,2}};
  int c_row0 [0:3] = '{'h62, 'h5A, 'h52, 'h22};
  int c_row3 [0:3] = '{'h36, 'h28, 'h2E, 'h0D};

  int total = 0, bad = 0;
  int t = -100, run_k = 0, base_a = 0, base_b = 0, drop_t = 0;
  int done_first = -1, en_cnt = 0;
  bit in_rst = 1'b1;
  logic [6:0]  addr_log [$];
  logic [31:0] hist_a [0:63];
  logic [31:0] hist_b [0:63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // ---- behavioural model: outputs as a function of the cycle index within the run ----
  function automatic logic [3:0] m_vld(int tt);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (run_k > 0) && (tt >= 2 + i) && (tt <= run_k + 1 + i);
    return v;
  endfunction

  function automatic logic [31:0] m_word(bit is_b, int tt);
    logic [31:0] d, w;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if ((tt >= 2 + i) && (tt <= run_k + 1 + i)) begin
        w = is_b ? mem_b[(base_b + tt - 2 - i) % 128] : mem_a[(base_a + tt - 2 - i) % 128];
        d[i*8 +: 8] = w[i*8 +: 8];
      end
    end
    return d;
  endfunction

  function automatic logic m_en(int tt);
    return (tt >= 0) && (tt < run_k);
  endfunction

  function automatic logic [6:0] m_addr(int base, int tt);
    return m_en(tt) ? 7'((base + tt) % 128) : 7'd0;
  endfunction

  function automatic logic m_busy(int tt);
    return (run_k > 0) && (tt >= 0) && (tt < run_k + MAT_DIM + DRAIN_CYC);
  endfunction

  function automatic logic m_done(int tt);
    int rise, last;
    rise = (run_k == 0) ? 1 : run_k + MAT_DIM + DRAIN_CYC + 1;
    last = (drop_t > rise) ? drop_t : rise;
    return (tt >= rise) && (tt <= last);
  endfunction

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    logic [31:0] ea, eb;
    logic [3:0]  ev;
    logic        ee, ebz, ed;
    logic [6:0]  eaa, eab;
    if (in_rst) begin
      ea = '0; eb = '0; ev = '0; ee = 1'b0; ebz = 1'b0; ed = 1'b0; eaa = '0; eab = '0;
    end else begin
      ea = m_word(1'b0, t); eb = m_word(1'b1, t); ev = m_vld(t);
      ee = m_en(t); ebz = m_busy(t); ed = m_done(t);
      eaa = m_addr(base_a, t); eab = m_addr(base_b, t);
    end
    check("en_a", en_a, ee);
    check("en_b", en_b, ee);
    check("addr_a", addr_a, eaa);
    check("addr_b", addr_b, eab);
    check("a_vld", a_vld, ev);
    check("b_vld", b_vld, ev);
    check("a_data", a_data, ea);
    check("b_data", b_data, eb);
    check("busy", busy, ebz);
    check("done", done_mat_mul, ed);
    if (en_a) begin
      en_cnt++;
      addr_log.push_back(addr_a);
    end
    if (done_mat_mul && done_first < 0) done_first = t;
    if (t >= 0 && t < 64) begin
      hist_a[t] = a_data;
      hist_b[t] = b_data;
    end
  end

  task automatic do_run(input int k, input int ba, input int bb, input int hold);
    int rise;
    @(posedge clk); #1;
    cfg_k = KW'(k); addr_base_a = AW'(ba); addr_base_b = AW'(bb); start_mat_mul = 1'b1;
    run_k = k; base_a = ba; base_b = bb; drop_t = hold; t = -1;
    done_first = -1; en_cnt = 0; addr_log.delete();
    for (int i = 0; i < 64; i++) begin hist_a[i] = '0; hist_b[i] = '0; end
    rise = (k == 0) ? 1 : k + MAT_DIM + DRAIN_CYC + 1;
    @(posedge clk); t = 0; #1;
    cfg_k = 8'd77; addr_base_a = 7'h55; addr_base_b = 7'h2A;
    if (hold == 0) start_mat_mul = 1'b0;
    repeat (rise + hold + 3) begin
      @(posedge clk); t = t + 1;
      if (t == hold) begin #1; start_mat_mul = 1'b0; end
    end
`ifdef MATMUL_SEQ_PERF_EN
    check("perf_model", perf_cycles, (k > 0) ? k + MAT_DIM + DRAIN_CYC : 0);
`endif
  endtask

  // Result of a 4x4 output-stationary array fed by the observed skewed streams.
  task automatic check_c(input string tag);
    int c;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        c = 0;
        for (int tt = 0; tt < 64; tt++) begin
          if (tt - j >= 0 && tt - i >= 0)
            c += int'(hist_a[tt-j][i*8 +: 8]) * int'(hist_b[tt-i][j*8 +: 8]);
        end
        if (i == 0) check({tag, "_c_row0"}, c, c_row0[j]);
        if (i == 3) check({tag, "_c_row3"}, c, c_row3[j]);
      end
    end
  endtask

  logic [6:0] exp_addr [0:3] = '{7'h7E, 7'h7F, 7'h00, 7'h01};

  initial begin
    for (int x = 0; x < 128; x++) begin
      mem_a[x] = 32'(x) * 32'h01030507 + 32'h11223344;
      mem_b[x] = 32'(x) * 32'h0705_0301 + 32'h5A5A1234;
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        mem_a['h10 + k][i*8 +: 8]        = 8'(a_mat[i][k]);
        mem_a[(126 + k) % 128][i*8 +: 8] = 8'(a_mat[i][k]);
        mem_b['h20 + k][i*8 +: 8]        = 8'(b_mat[k][i]);
        mem_b[(124 + k) % 128][i*8 +: 8] = 8'(b_mat[k][i]);
      end
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b1; in_rst = 1'b0;

    // reference load, start pulse
    do_run(4, 'h10, 'h20, 0);
    check("done_cycle", done_first, 17);
    for (int k = 0; k < 4; k++) check("a_lane3", hist_a[5+k][31:24], a_mat[3][k]);
    check("a_lane3_pre", hist_a[4][31:24], 0);
    check("a_lane3_post", hist_a[9][31:24], 0);
    check_c("run1");
`ifdef MATMUL_SEQ_PERF_EN
    check("perf16", perf_cycles, 16);
`endif

    // address wrap
    do_run(4, 'h7E, 'h7C, 0);
    check("en_a_cnt_wrap", en_cnt, 4);
    check("addr_log_size", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("addr_wrap", addr_log[i], exp_addr[i]);
    check_c("wrap");

    // K = 0: no reads, done next cycle
    do_run(0, 'h05, 'h06, 0);
    check("k0_en_cnt", en_cnt, 0);
    check("k0_done_cycle", done_first, 1);

    // reset in FETCH cycle 2
    @(posedge clk); #1;
    cfg_k = 8'd4; addr_base_a = 7'h10; addr_base_b = 7'h20; start_mat_mul = 1'b1;
    run_k = 4; base_a = 'h10; base_b = 'h20; drop_t = 0; t = -1;
    @(posedge clk); t = 0; #1 start_mat_mul = 1'b0;
    @(posedge clk); t = 1;
    @(posedge clk); t = 2;
    #2 reset = 1'b0; in_rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_en", {en_a, en_b}, 0);
    check("rst_addr", {addr_a, addr_b}, 0);
    check("rst_data", {a_data, b_data}, 0);
    check("rst_vld", {a_vld, b_vld}, 0);
    check("rst_done", done_mat_mul, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1; in_rst = 1'b0; t = -100;
    do_run(5, 'h40, 'h41, 0);
    check("post_rst_done", done_first, 18);
    check("post_rst_en_cnt", en_cnt, 5);

    // start held through DONE
    do_run(4, 'h10, 'h20, 25);
    check("hold_en_cnt", en_cnt, 4);
    check("hold_done_cycle", done_first, 17);
    check_c("hold");
`ifdef MATMUL_SEQ_PERF_EN
    check("perf16_hold", perf_cycles, 16);
`endif

    // assorted K and bases, model-checked
    do_run(1, 'h00, 'h7F, 0);
    do_run(3, 'h7D, 'h02, 2);
    do_run(20, 'h70, 'h30, 0);
    check("k20_en_cnt", en_cnt, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
